// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer (shift-add / restoring divide).
// Optional MULDIV_EARLY_OUT_EN resolves zero operands, divide-by-zero and signed overflow at accept.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t            state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
    logic [2:0]        f3_q, f3_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d, valid_q, valid_d;
    logic              a_sgn, b_sgn, ge, eo_hit;
    logic [XLEN-1:0]   a_mag, b_mag, div_sub, quo, rem, quo_fix, rem_fix, fin, eo_res;
    logic [XLEN:0]     mul_sum, div_rem;
    logic [2*XLEN-1:0] step, prod_fix;
    assign a_sgn = (i_funct3 == 3'b001 || i_funct3 == 3'b010 || i_funct3 == 3'b100 || i_funct3 == 3'b110) & i_rs1[XLEN-1];
    assign b_sgn = (i_funct3 == 3'b001 || i_funct3 == 3'b100 || i_funct3 == 3'b110) & i_rs2[XLEN-1];
    assign a_mag = a_sgn ? -i_rs1 : i_rs1;
    assign b_mag = b_sgn ? -i_rs2 : i_rs2;
    // multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, acc_q[0] ? b_q : '0};
    // divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign div_rem = acc_q[2*XLEN-1:XLEN-1];
    assign ge      = div_rem >= {1'b0, b_q};
    assign div_sub = div_rem[XLEN-1:0] - b_q;
    assign step    = f3_q[2] ? {ge ? div_sub : div_rem[XLEN-1:0], acc_q[XLEN-2:0], ge}
                             : {mul_sum, acc_q[XLEN-1:1]};
    assign prod_fix = neg_q ? -step : step;
    assign quo      = step[XLEN-1:0];
    assign rem      = step[2*XLEN-1:XLEN];
    // a zero divisor keeps the all-ones quotient regardless of operand signs
    assign quo_fix  = (neg_q & ~bz_q) ? -quo : quo;
    assign rem_fix  = rneg_q ? -rem : rem;
    assign fin = !f3_q[2] ? (f3_q[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN])
                          : (f3_q[1] ? rem_fix : quo_fix);
`ifdef MULDIV_EARLY_OUT_EN
    logic ovf;
    assign ovf    = i_funct3[2] & ~i_funct3[0] & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_rs2);
    assign eo_hit = i_funct3[2] ? (i_rs2 == '0 || i_rs1 == '0 || ovf) : (i_rs1 == '0 || i_rs2 == '0);
    assign eo_res = !i_funct3[2] ? '0 :
                    i_rs2 == '0  ? (i_funct3[1] ? i_rs1 : '1) :
                    i_rs1 == '0  ? '0 :
                    (i_funct3[1] ? '0 : i_rs1);
`else
    assign eo_hit = 1'b0;
    assign eo_res = '0;
`endif
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        f3_d     = f3_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bz_d     = bz_q;
        valid_d  = valid_q;
        result_d = result_q;
        if (i_flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_valid) begin
                    f3_d     = i_funct3;
                    acc_d    = {{XLEN{1'b0}}, i_funct3[2] ? a_mag : b_mag};
                    b_d      = i_funct3[2] ? b_mag : a_mag;
                    neg_d    = a_sgn ^ b_sgn;
                    rneg_d   = a_sgn;
                    bz_d     = i_rs2 == '0;
                    cnt_d    = '0;
                    state_d  = eo_hit ? DONE : CALC;
                    valid_d  = eo_hit;
                    result_d = eo_hit ? eo_res : result_q;
                end
                CALC: begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = fin;
                    end
                end
                DONE: if (i_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            f3_q     <= f3_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bz_q     <= bz_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end
    assign o_ready  = state_q == IDLE;
    assign o_busy   = state_q != IDLE;
    assign o_valid  = valid_q;
    assign o_result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed RV32M vectors checked against literals and an arithmetic reference model.
module tb_muldiv_seq;
    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b1;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_rs1 = '0, i_rs2 = '0;
    logic        o_ready, o_valid, o_busy;
    logic [31:0] o_result;
    logic [31:0] exp_res = '0;
    int          errors = 0, checks = 0;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif
    muldiv_seq #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
    );
    always #5 i_clk = ~i_clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic signed [31:0] qa, qb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        qa = $signed(a);
        qb = $signed(b);
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return b == 0 ? 32'hffffffff : (a == 32'h80000000 && b == 32'hffffffff) ? a : 32'(qa / qb);
            3'd5: return b == 0 ? 32'hffffffff : a / b;
            3'd6: return b == 0 ? a : (a == 32'h80000000 && b == 32'hffffffff) ? 32'h0 : 32'(qa % qb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction
    function automatic bit early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return EO && (f[2] ? (b == 0 || a == 0 || (!f[0] && a == 32'h80000000 && b == 32'hffffffff))
                           : (a == 0 || b == 0));
    endfunction
    // every cycle a result is presented it must match the model and keep the pipeline stalled
    always @(negedge i_clk) if (i_rst_n && o_valid) begin
        chk("model_result", o_result, exp_res);
        chk("busy_done", {31'b0, o_busy}, 32'd1);
        chk("ready_done", {31'b0, o_ready}, 32'd0);
    end
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input bit uselit, input int hold);
        int lat;
        logic [31:0] r;
        @(negedge i_clk);
        chk("ready_idle", {31'b0, o_ready}, 32'd1);
        exp_res  = model(f, a, b);
        i_valid  = 1'b1;
        i_funct3 = f;
        i_rs1    = a;
        i_rs2    = b;
        i_ready  = (hold == 0);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge i_clk);
            lat++;
            if (!o_valid) chk("busy_calc", {31'b0, o_busy}, 32'd1);
        end while (!o_valid && lat < 100);
        chk("latency", 32'(lat), early(f, a, b) ? 32'd1 : 32'd33);
        if (uselit) chk("result_lit", o_result, lit);
        r = o_result;
        for (int k = 0; k < hold; k++) begin
            @(negedge i_clk);
            chk("hold_valid", {31'b0, o_valid}, 32'd1);
            chk("hold_result", o_result, r);
            chk("hold_ready", {31'b0, o_ready}, 32'd0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("ret_valid", {31'b0, o_valid}, 32'd0);
        chk("ret_ready", {31'b0, o_ready}, 32'd1);
    endtask
    task automatic abort_op(input bit use_reset);
        bit seen;
        @(negedge i_clk);
        exp_res  = model(3'd4, 32'd100, 32'd7);
        i_valid  = 1'b1;
        i_funct3 = 3'd4;
        i_rs1    = 32'd100;
        i_rs2    = 32'd7;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        if (!use_reset) begin
            i_flush = 1'b1;
            @(posedge i_clk);
            #1 i_flush = 1'b0;
            chk("flush_ready", {31'b0, o_ready}, 32'd1);
            chk("flush_busy", {31'b0, o_busy}, 32'd0);
        end else begin
            #2 i_rst_n = 1'b0;
            #1;
            chk("rst_ready", {31'b0, o_ready}, 32'd1);
            chk("rst_busy", {31'b0, o_busy}, 32'd0);
            chk("rst_valid", {31'b0, o_valid}, 32'd0);
            chk("rst_result", o_result, 32'd0);
            @(negedge i_clk);
            i_rst_n = 1'b1;
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid) seen = 1'b1;
        end
        chk("abort_no_valid", {31'b0, seen}, 32'd0);
        run_op(3'd0, 32'd3, 32'd3, 32'd9, 1'b1, 0);
    endtask
    initial begin
        #1;
        chk("reset_ready", {31'b0, o_ready}, 32'd1);
        chk("reset_valid", {31'b0, o_valid}, 32'd0);
        chk("reset_busy", {31'b0, o_busy}, 32'd0);
        chk("reset_result", o_result, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op(3'd0, 32'd7, 32'd6, 32'd42, 1'b1, 0);
        run_op(3'd1, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b1, 0);
        run_op(3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 1'b1, 5);
        run_op(3'd2, 32'hffffffff, 32'd2, 32'hffffffff, 1'b1, 0);
        run_op(3'd4, 32'hfffffff9, 32'd2, 32'hfffffffd, 1'b1, 0);
        run_op(3'd6, 32'hfffffff9, 32'd2, 32'hffffffff, 1'b1, 0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, 0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b1, 0);
        run_op(3'd4, 32'd5, 32'd0, 32'hffffffff, 1'b1, 0);
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 1'b1, 0);
        run_op(3'd4, 32'hfffffffb, 32'd0, 32'hffffffff, 1'b1, 0);
        run_op(3'd4, 32'h80000000, 32'hffffffff, 32'h80000000, 1'b1, 0);
        run_op(3'd6, 32'h80000000, 32'hffffffff, 32'h00000000, 1'b1, 2);
        run_op(3'd0, 32'd0, 32'd1234, 32'd0, 1'b1, 0);
        for (int i = 0; i < 6; i++) run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 32'd0, 1'b0, 0);
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_flush  = 1'b1;
        i_funct3 = 3'd0;
        i_rs1    = 32'd3;
        i_rs2    = 32'd3;
        @(posedge i_clk);
        #1 begin i_valid = 1'b0; i_flush = 1'b0; end
        chk("flush_beats_accept_ready", {31'b0, o_ready}, 32'd1);
        chk("flush_beats_accept_busy", {31'b0, o_busy}, 32'd0);
        abort_op(1'b0);
        abort_op(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide instructions.
- Sits beside the single-cycle ALU in the execute stage; the decoder routes OP funct7=0000001 instructions here instead of the ALU.
- Runs one shift-add or restoring-subtract iteration per cycle, with a valid/ready handshake on both sides.
- Drives a stall to the pipeline while busy and supports a flush abort.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  request valid; operands and funct3 are sampled on accept.
- o_ready  output  1  ready to accept; high only in IDLE.
- i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1  input  XLEN  operand A (dividend / multiplicand).
- i_rs2  input  XLEN  operand B (divisor / multiplier).
- i_flush  input  1  abort; the pipeline is being redirected.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_result  output  XLEN  result.
- o_busy  output  1  stall request: high in CALC, and in DONE until the result is taken.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, o_valid=0, o_result=0, o_busy=0, o_ready=1.
  - Internal accumulators and the counter are cleared.
  - Reset mid-operation discards the operation with no output.
- States:
  - IDLE: o_ready=1. Accept when i_valid & o_ready & !i_flush.
    - On accept, latch funct3 and the operand magnitudes.
    - Signed ops take the absolute value of each signed operand and record the result sign.
    - MULHSU treats rs2 as unsigned.
    - Counter=0, go to CALC.
  - CALC:
    - Multiply: one iteration per cycle over the 2*XLEN product, shift-add on the LSB of the multiplier.
    - Divide: one iteration per cycle of restoring division; shift the remainder left, bring in the next dividend bit, subtract the divisor if it is not greater.
    - Counter increments each cycle. After iteration XLEN-1, apply sign fixup, select the result, and go to DONE.
  - DONE: o_valid=1 and o_result held stable until i_ready; on i_valid/o_valid & i_ready go to IDLE.
- Latency: accept edge at cycle T; o_valid is high from cycle T+XLEN+1 (33 for XLEN=32). Throughput: at most one op per XLEN+2 cycles.
- Result select:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Sign fixup:
  - Product is negated if the operand signs differ (signed ops only).
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero (rs2=0):
  - DIV/DIVU quotient = all ones; REM/REMU remainder = rs1.
  - No trap. Latency unchanged unless the optional feature below is enabled.
- Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient=0x80000000, remainder=0. Produced by fixup; no special state.
- Flush:
  - i_flush=1 in any state → IDLE on the next edge, o_valid=0, result discarded.
  - Flush beats accept in the same cycle (no accept).
- o_busy is combinational from state; o_ready = (state==IDLE).
- A back-to-back request while in DONE is not accepted until the return to IDLE.

Optional Feature:
- MULDIV_EARLY_OUT_EN
- Defined:
  - In IDLE, on accept, the block detects divide-by-zero, signed overflow, or an operand equal to zero (mul: either operand; div: rs1).
  - It computes the architectural result directly and goes straight to DONE, giving o_valid at T+1.
- Undefined:
  - All operations take the full XLEN+1 cycle latency.
  - Special-case results are produced by the normal iteration plus fixup.

Test Plan:
- MUL rs1=7, rs2=6 → o_result=42 at cycle T+33; o_busy high T+1..T+33.
- MULH rs1=0xFFFFFFFF(-1), rs2=0xFFFFFFFF(-1) → 0x00000000; MULHU same operands → 0xFFFFFFFE; MULHSU rs1=-1, rs2=2 → 0xFFFFFFFF.
- DIV rs1=-7, rs2=2 → -3 (0xFFFFFFFD); REM same operands → -1 (0xFFFFFFFF); DIVU rs1=100, rs2=7 → 14; REMU → 2.
- DIV rs1=5, rs2=0 → 0xFFFFFFFF; REM → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - Check latency 33 without MULDIV_EARLY_OUT_EN and 1 with it.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid → o_valid and o_result stable, o_ready=0; i_ready=1 → IDLE next cycle.
- Flush at CALC cycle 10, then the async reset asserted mid-CALC → o_valid never rises for the aborted op.
  - After each abort, a new MUL 3×3 returns 9.
